fp_mul_seq: RTL and testbench

- Multi-cycle, parameterised floating-point multiplier. It is the sequential successor of the team's combinational FP multiplier and keeps the same operand format and the same status flags.
- Operand format is {sign, E-bit biased exponent, M-bit mantissa} with a hidden leading 1.
- It replaces the single-cycle (M+1)x(M+1) array with an iterative shift-add datapath controlled by a small FSM and a start/done handshake, so it can sit between register-file-style producers and consumers in the lab datapath.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_classify.sv | 28 ++
 rtl/fp_mul_seq.sv | 213 +++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and format helpers for the floating-point multiplier family.
package fp_pkg;

   typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} fp_state_t;

   typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

   function automatic int unsigned bias(input int unsigned e);
      return (32'd1 << (e - 1)) - 32'd1;
   endfunction

   function automatic int unsigned exp_max(input int unsigned e);
      return (32'd1 << e) - 32'd1;
   endfunction

   // Quiet NaN right-aligned in 64 bits; callers cast down to their operand width.
   function automatic logic [63:0] qnan(input int unsigned e, input int unsigned m);
      return (64'(exp_max(e)) << m) | (64'd1 << (m - 1));
   endfunction

endpackage

// File: rtl/fp_classify.sv
// Splits an operand into sign/exponent/mantissa and classifies it (denormals count as zero).
module fp_classify
   import fp_pkg::*;
#(
   parameter int unsigned E = 8,
   parameter int unsigned M = 8
) (
   input  logic [E+M:0] op_i,
   output fp_class_t    cls_o,
   output logic         sign_o,
   output logic [E-1:0] exp_o,
   output logic [M-1:0] mant_o
);

   assign sign_o = op_i[E+M];
   assign exp_o  = op_i[E+M-1:M];
   assign mant_o = op_i[M-1:0];

   always_comb begin
      cls_o = FP_NORM;
      if (exp_o == '0) begin
         cls_o = FP_ZERO;
      end else if (exp_o == '1) begin
         cls_o = (mant_o == '0) ? FP_INF : FP_NAN;
      end
   end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: shift-add mantissa product over M+1 cycles,
// one normalise cycle, then a one-cycle done pulse with registered result and flags.
module fp_mul_seq
   import fp_pkg::*;
#(
   parameter int unsigned E = 8,
   parameter int unsigned M = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [E+M:0] X,
   input  logic [E+M:0] Y,
   output logic         busy,
   output logic         done,
   output logic [E+M:0] result,
   output logic         zero,
   output logic         underflow,
   output logic         overflow,
   output logic         nan
);

   localparam int unsigned W  = 1 + E + M;
   localparam int unsigned PW = 2 * M + 2;
   localparam int unsigned CW = $clog2(M + 1);

   localparam logic [W-1:0]        QNAN = W'(qnan(E, M));
   localparam logic signed [E+1:0] BIAS = (E+2)'(bias(E));
   localparam logic signed [E+1:0] ONE  = (E+2)'(1);
   localparam logic [E:0]          EMAX = (E+1)'(exp_max(E));

   fp_class_t    cls_x, cls_y;
   logic         sx, sy;
   logic [E-1:0] ex, ey;
   logic [M-1:0] mx, my;

   fp_classify #(.E(E), .M(M)) u_class_x (
      .op_i   (X),
      .cls_o  (cls_x),
      .sign_o (sx),
      .exp_o  (ex),
      .mant_o (mx)
   );

   fp_classify #(.E(E), .M(M)) u_class_y (
      .op_i   (Y),
      .cls_o  (cls_y),
      .sign_o (sy),
      .exp_o  (ey),
      .mant_o (my)
   );

   fp_state_t     state_q, state_d;
   fp_class_t     cls_x_q, cls_x_d, cls_y_q, cls_y_d;
   logic          sign_q, sign_d;
   logic [E-1:0]  ex_q, ex_d, ey_q, ey_d;
   logic [M:0]    mcand_q, mcand_d, mplier_q, mplier_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  result_q, result_d;
   logic          zero_q, zero_d, uf_q, uf_d, of_q, of_d, nan_q, nan_d;

   logic signed [E+1:0] exp_raw, exp_n;
   logic [M-1:0]        mant_n;
   logic [W-1:0]        res_n;
   logic                zero_n, uf_n, of_n, nan_n;
   logic                x_zero, x_inf, x_nan, y_zero, y_inf, y_nan;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cls_x_q  <= FP_ZERO;
         cls_y_q  <= FP_ZERO;
         sign_q   <= 1'b0;
         ex_q     <= '0;
         ey_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         uf_q     <= 1'b0;
         of_q     <= 1'b0;
         nan_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cls_x_q  <= cls_x_d;
         cls_y_q  <= cls_y_d;
         sign_q   <= sign_d;
         ex_q     <= ex_d;
         ey_q     <= ey_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         uf_q     <= uf_d;
         of_q     <= of_d;
         nan_q    <= nan_d;
      end
   end

   // Normalise and special-case resolution, consumed only while in NORM.
   always_comb begin
      x_zero = (cls_x_q == FP_ZERO);
      x_inf  = (cls_x_q == FP_INF);
      x_nan  = (cls_x_q == FP_NAN);
      y_zero = (cls_y_q == FP_ZERO);
      y_inf  = (cls_y_q == FP_INF);
      y_nan  = (cls_y_q == FP_NAN);

      exp_raw = $signed({2'b00, ex_q}) + $signed({2'b00, ey_q}) - BIAS;
      if (acc_q[PW-1]) begin
         mant_n = acc_q[2*M:M+1];
         exp_n  = exp_raw + ONE;
      end else begin
         mant_n = acc_q[2*M-1:M];
         exp_n  = exp_raw;
      end

      res_n  = '0;
      zero_n = 1'b0;
      uf_n   = 1'b0;
      of_n   = 1'b0;
      nan_n  = 1'b0;
      if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero)) begin
         res_n = QNAN;
         nan_n = 1'b1;
      end else if (x_inf || y_inf) begin
         res_n = {sign_q, {E{1'b1}}, {M{1'b0}}};
      end else if (x_zero || y_zero) begin
         res_n  = {sign_q, {(E+M){1'b0}}};
         zero_n = 1'b1;
      end else if (exp_n[E+1] || (exp_n == '0)) begin
         res_n = {sign_q, {(E+M){1'b0}}};
         uf_n  = 1'b1;
      end else if (exp_n[E:0] >= EMAX) begin
         res_n = {sign_q, {E{1'b1}}, {M{1'b0}}};
         of_n  = 1'b1;
      end else begin
         res_n = {sign_q, exp_n[E-1:0], mant_n};
      end
   end

   always_comb begin
      state_d  = state_q;
      cls_x_d  = cls_x_q;
      cls_y_d  = cls_y_q;
      sign_d   = sign_q;
      ex_d     = ex_q;
      ey_d     = ey_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      uf_d     = uf_q;
      of_d     = of_q;
      nan_d    = nan_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cls_x_d  = cls_x;
               cls_y_d  = cls_y;
               sign_d   = sx ^ sy;
               ex_d     = ex;
               ey_d     = ey;
               mcand_d  = {1'b1, mx};
               mplier_d = {1'b1, my};
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = (cls_x != FP_NORM || cls_y != FP_NORM) ? NORM : MULT;
            end
         end
         MULT: begin
            if (mplier_q[cnt_q]) begin
               acc_d = acc_q + (PW'(mcand_q) << cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(M)) begin
               state_d = NORM;
            end
         end
         NORM: begin
            result_d = res_n;
            zero_d   = zero_n;
            uf_d     = uf_n;
            of_d     = of_n;
            nan_d    = nan_n;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign underflow = uf_q;
   assign overflow  = of_q;
   assign nan       = nan_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed vectors, randomised operands against an
// arithmetic reference model, reset abort, ignored starts and a wide-mantissa instance.
module tb_fp_mul_seq;

   logic        clk;
   logic        reset;
   logic        start1, start2;
   logic [16:0] x1, y1, res1;
   logic [22:0] x2, y2, res2;
   logic        busy1, done1, zero1, uf1, of1, nan1;
   logic        busy2, done2, zero2, uf2, of2, nan2;

   int checks;
   int errors;

   fp_mul_seq #(.E(8), .M(8)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .start     (start1),
      .X         (x1),
      .Y         (y1),
      .busy      (busy1),
      .done      (done1),
      .result    (res1),
      .zero      (zero1),
      .underflow (uf1),
      .overflow  (of1),
      .nan       (nan1)
   );

   fp_mul_seq #(.E(6), .M(16)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .start     (start2),
      .X         (x2),
      .Y         (y2),
      .busy      (busy2),
      .done      (done2),
      .result    (res2),
      .zero      (zero2),
      .underflow (uf2),
      .overflow  (of2),
      .nan       (nan2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int ND = 9;
   localparam logic [16:0] DX [ND] = '{17'h07F80, 17'h07F80, 17'h17F80, 17'h00000, 17'h00000,
                                       17'h0FE00, 17'h00100, 17'h1FF00, 17'h0FF01};
   localparam logic [16:0] DY [ND] = '{17'h08000, 17'h07F80, 17'h07F80, 17'h08000, 17'h0FF00,
                                       17'h0FE00, 17'h00100, 17'h08000, 17'h08000};
   localparam logic [16:0] DR [ND] = '{17'h08080, 17'h08020, 17'h18020, 17'h00000, 17'h0FF80,
                                       17'h0FF00, 17'h00000, 17'h1FF00, 17'h0FF80};
   // Flag vectors are {nan, overflow, underflow, zero}.
   localparam logic [3:0]  DF [ND] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000,
                                       4'b0100, 4'b0010, 4'b0000, 4'b1000};
   localparam int          DL [ND] = '{11, 11, 11, 2, 2, 11, 11, 2, 2};

   // Reference: decode fields, multiply significands with '*', normalise by magnitude.
   function automatic void ref_mul(input int e, input int m, input logic [63:0] x,
                                   input logic [63:0] y, output logic [63:0] res,
                                   output logic [3:0] fl, output bit spec);
      longint emax, bs, mmask, xe, ye, xm, ym, sgn, p, ex, mant;
      bit xz, yz, xi, yi, xn, yn;
      emax  = (longint'(1) << e) - 1;
      bs    = (longint'(1) << (e - 1)) - 1;
      mmask = (longint'(1) << m) - 1;
      xe    = longint'(x >> m) & emax;
      ye    = longint'(y >> m) & emax;
      xm    = longint'(x) & mmask;
      ym    = longint'(y) & mmask;
      sgn   = (longint'(x >> (e + m)) ^ longint'(y >> (e + m))) & 1;
      xz = (xe == 0);
      yz = (ye == 0);
      xi = (xe == emax) && (xm == 0);
      yi = (ye == emax) && (ym == 0);
      xn = (xe == emax) && (xm != 0);
      yn = (ye == emax) && (ym != 0);
      spec = xz || yz || xi || yi || xn || yn;
      fl   = 4'b0000;
      if (xn || yn || (xz && yi) || (xi && yz)) begin
         res = 64'((emax << m) | (longint'(1) << (m - 1)));
         fl  = 4'b1000;
      end else if (xi || yi) begin
         res = 64'((sgn << (e + m)) | (emax << m));
      end else if (xz || yz) begin
         res = 64'(sgn << (e + m));
         fl  = 4'b0001;
      end else begin
         p  = (mmask + 1 + xm) * (mmask + 1 + ym);
         ex = xe + ye - bs;
         if (p >= (longint'(1) << (2 * m + 1))) begin
            mant = (p >> (m + 1)) & mmask;
            ex   = ex + 1;
         end else begin
            mant = (p >> m) & mmask;
         end
         if (ex >= emax) begin
            res = 64'((sgn << (e + m)) | (emax << m));
            fl  = 4'b0100;
         end else if (ex <= 0) begin
            res = 64'(sgn << (e + m));
            fl  = 4'b0010;
         end else begin
            res = 64'((sgn << (e + m)) | (ex << m) | mant);
         end
      end
   endfunction

   function automatic logic [63:0] rand_op(input int e, input int m);
      longint emax, ex, mant, sgn;
      int unsigned r;
      emax = (longint'(1) << e) - 1;
      r    = $urandom_range(0, 9);
      if (r == 0)      ex = 0;
      else if (r == 1) ex = emax;
      else             ex = longint'($urandom_range(1, 32'(emax - 1)));
      mant = longint'($urandom) & ((longint'(1) << m) - 1);
      if (r == 1 && $urandom_range(0, 1) == 0) mant = 0;
      sgn = longint'($urandom_range(0, 1));
      return 64'((sgn << (e + m)) | (ex << m) | mant);
   endfunction

   // Drives one start, reports done latency (start edge = 1), outputs at done, and whether
   // anything was still active one cycle after done.
   task automatic run_op(input int which, input logic [63:0] x, input logic [63:0] y,
                         output int lat, output logic [63:0] res, output logic [3:0] fl,
                         output logic tail);
      @(negedge clk);
      if (which == 0) begin
         x1 = x[16:0]; y1 = y[16:0]; start1 = 1'b1;
      end else begin
         x2 = x[22:0]; y2 = y[22:0]; start2 = 1'b1;
      end
      @(posedge clk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      lat = 1;
      while (!((which == 0) ? done1 : done2) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (which == 0) begin
         res = 64'(res1); fl = {nan1, of1, uf1, zero1};
      end else begin
         res = 64'(res2); fl = {nan2, of2, uf2, zero2};
      end
      @(posedge clk); #1;
      tail = (which == 0) ? (done1 | busy1) : (done2 | busy2);
   endtask

   task automatic test_reset();
      reset = 1'b1; start1 = 1'b1; start2 = 1'b1;
      x1 = 17'h07F80; y1 = 17'h08000; x2 = '0; y2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy1, done1, zero1, uf1, of1, nan1} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl1 got %b want 000000", {busy1, done1, zero1, uf1, of1, nan1});
      end
      checks++;
      if (res1 !== 17'h0) begin
         errors++;
         $display("FAIL reset_result1 got %h want 00000", res1);
      end
      checks++;
      if ({busy2, done2, zero2, uf2, of2, nan2} !== 6'b0 || res2 !== 23'h0) begin
         errors++;
         $display("FAIL reset_dut2 got %b/%h want 000000/000000",
                  {busy2, done2, zero2, uf2, of2, nan2}, res2);
      end
      reset = 1'b0; start1 = 1'b0; start2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      int lat; logic [63:0] res; logic [3:0] fl; logic tail;
      for (int i = 0; i < ND; i++) begin
         run_op(0, 64'(DX[i]), 64'(DY[i]), lat, res, fl, tail);
         checks++;
         if (res !== 64'(DR[i]) || fl !== DF[i]) begin
            errors++;
            $display("FAIL directed[%0d] result/flags got %h/%b want %h/%b",
                     i, res, fl, DR[i], DF[i]);
         end
         checks++;
         if (lat !== DL[i]) begin
            errors++;
            $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, DL[i]);
         end
         checks++;
         if (tail !== 1'b0) begin
            errors++;
            $display("FAIL directed_done_width[%0d] got active after done, want idle", i);
         end
      end
   endtask

   task automatic test_random();
      int lat, which, e, m; logic [63:0] x, y, res, eres; logic [3:0] fl, efl;
      logic tail; bit spec;
      for (int i = 0; i < 100; i++) begin
         which = (i % 4 == 3) ? 1 : 0;
         e = (which == 1) ? 6 : 8;
         m = (which == 1) ? 16 : 8;
         x = rand_op(e, m);
         y = rand_op(e, m);
         ref_mul(e, m, x, y, eres, efl, spec);
         run_op(which, x, y, lat, res, fl, tail);
         checks++;
         if (res !== eres || fl !== efl) begin
            errors++;
            $display("FAIL random[%0d] dut%0d x=%h y=%h result/flags got %h/%b want %h/%b",
                     i, which + 1, x, y, res, fl, eres, efl);
         end
         checks++;
         if (lat !== (spec ? 2 : m + 3) || tail !== 1'b0) begin
            errors++;
            $display("FAIL random_timing[%0d] latency/tail got %0d/%b want %0d/0",
                     i, lat, tail, spec ? 2 : m + 3);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [63:0] res; logic [3:0] fl; logic tail; bit seen;
      run_op(0, 64'h07F80, 64'h07F80, lat, res, fl, tail);
      @(negedge clk);
      x1 = 17'h07F80; y1 = 17'h08000; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL abort_busy_before got %b want 1", busy1);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({busy1, done1, zero1, uf1, of1, nan1} !== 6'b0 || res1 !== 17'h0) begin
         errors++;
         $display("FAIL abort_outputs got %b/%h want 000000/00000",
                  {busy1, done1, zero1, uf1, of1, nan1}, res1);
      end
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done1 || busy1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_done got activity after abort, want none");
      end
      run_op(0, 64'h07F80, 64'h08000, lat, res, fl, tail);
      checks++;
      if (res !== 64'h08080 || fl !== 4'b0000 || lat !== 11) begin
         errors++;
         $display("FAIL abort_recover result/flags/latency got %h/%b/%0d want 08080/0000/11",
                  res, fl, lat);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      x1 = 17'h07F80; y1 = 17'h08000; start1 = 1'b1;
      @(posedge clk); #1;
      x1 = 17'h0FE00; y1 = 17'h0FE00;
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 40) begin
         start1 = ~start1;
         @(posedge clk); #1;
         lat++;
      end
      start1 = 1'b1;
      checks++;
      if (lat !== 11 || res1 !== 17'h08080 || {nan1, of1, uf1, zero1} !== 4'b0000) begin
         errors++;
         $display("FAIL ignore_busy latency/result/flags got %0d/%h/%b want 11/08080/0000",
                  lat, res1, {nan1, of1, uf1, zero1});
      end
      @(posedge clk); #1;
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         errors++;
         $display("FAIL ignore_done busy/done got %b/%b want 0/0", busy1, done1);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy1 !== 1'b0 || res1 !== 17'h08080) begin
         errors++;
         $display("FAIL ignore_hold busy/result got %b/%h want 0/08080", busy1, res1);
      end
   endtask

   task automatic test_wide();
      int lat; logic [63:0] res; logic [3:0] fl; logic tail;
      run_op(1, 64'h1F8000, 64'h200000, lat, res, fl, tail);
      checks++;
      if (res !== 64'h208000 || fl !== 4'b0000) begin
         errors++;
         $display("FAIL wide_result result/flags got %h/%b want 208000/0000", res, fl);
      end
      checks++;
      if (lat !== 19 || tail !== 1'b0) begin
         errors++;
         $display("FAIL wide_latency latency/tail got %0d/%b want 19/0", lat, tail);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      x1 = '0; y1 = '0; x2 = '0; y2 = '0;
      test_reset();
      test_directed();
      test_wide();
      test_random();
      test_reset_mid();
      test_ignore_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
